// File: rtl/smult_share_arbiter.sv
// smult_share_arbiter: lets N_REQ requesters share one combinational signed
// 16x16 multiplier. Operands are registered in front of the multiplier and the
// 32-bit product behind it. Each response is tagged with the requester index.
// Build option: define SMULT_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest index wins.
module smult_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_p,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]         state;
    logic signed [15:0] op_a;
    logic signed [15:0] op_b;
    logic [ID_W-1:0]    op_id;
    logic signed [31:0] product;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic               grant_any;
    logic [15:0]        sel_a;
    logic [15:0]        sel_b;
    logic               xfer;

`ifdef SMULT_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]    ptr;
`endif

    // Arbiter: choose one valid requester, scanning in priority order
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves a value undriven and no latch is inferred.
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef SMULT_ARB_ROUND_ROBIN_EN
            cand = ID_W'((int'(ptr) + 1 + k) % N_REQ);
`else
            cand = ID_W'(k);
`endif
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        grant[grant_id] = grant_any;
    end

    // Operand mux: route the granted requester's a/b slices to the operand registers
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_a = req_a[16*k +: 16];
                sel_b = req_b[16*k +: 16];
            end
        end
    end

    // Requests are accepted only in IDLE and never while reset is asserted
    assign req_ready = (state == S_IDLE && !rst) ? grant : '0;
    assign xfer      = |req_ready;
    assign busy      = (state != S_IDLE);

    // Shared multiplier: full-precision signed product, fed only from the operand registers
    assign product = op_a * op_b;

    // FSM with operand capture in IDLE and product capture at the end of MUL
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= S_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_p     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        op_id <= grant_id;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    rsp_p     <= product;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SMULT_ARB_ROUND_ROBIN_EN
    // Priority pointer: remembers the last winner so the next search starts just past it
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= ID_W'(N_REQ - 1);
        end else if (xfer) begin
            ptr <= grant_id;
        end
    end
`endif

endmodule

// File: tb/tb_smult_share_arbiter.sv
// Testbench for smult_share_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_smult_share_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_a;
    logic [16*N-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_p;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    smult_share_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: one job at a time, response visible two cycles after accept
    bit          m_job     = 1'b0;
    int          m_start   = 0;
    logic [31:0] m_p       = '0;
    int          m_id      = 0;
    logic [31:0] m_last_p  = '0;
    int          m_last_id = 0;
    int          m_ptr     = N - 1;
    int          cyc       = 0;

    // Observations used for stimulus reactions and directed checks
    logic [N-1:0] seen_xfer;
    logic [N-1:0] last_ready;
    int           n_rsp = 0;
    logic [31:0]  rsp_seen_p;
    int           rsp_seen_id;
    int           grants[$];

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int w;
        w = -1;
`ifdef SMULT_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && v[(ptr + k) % N]) w = (ptr + k) % N;
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) w = k;
        end
`endif
        return w;
    endfunction

    function automatic int rand_op();
        case ($urandom_range(0, 5))
            0:       return -32768;
            1:       return 32767;
            2:       return -1;
            3:       return 0;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]       = 1'b1;
        req_a[16*i +: 16]  = 16'(a);
        req_b[16*i +: 16]  = 16'(b);
    endtask

    // One clock cycle: compare outputs with the model, observe handshakes, advance the model
    task automatic tick();
        int              w;
        logic [N-1:0]    exp_ready;
        bit              exp_rv;
        logic signed [15:0] ta;
        logic signed [15:0] tb;
        @(negedge clk);
        exp_ready = '0;
        w = -1;
        if (!m_job && !rst) begin
            w = pick(req_valid, m_ptr);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        exp_rv = m_job && (cyc >= m_start + 2);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy",      32'(busy),      32'(m_job));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rsp_p",     rsp_p,          exp_rv ? m_p : m_last_p);
        check("rsp_id",    32'(rsp_id),    32'(exp_rv ? m_id : m_last_id));

        last_ready = req_ready;
        seen_xfer  = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (seen_xfer[i]) grants.push_back(i);
        end
        if (rsp_valid && rsp_ready && !rst) begin
            n_rsp++;
            rsp_seen_p  = rsp_p;
            rsp_seen_id = int'(rsp_id);
        end

        if (rst) begin
            m_job     = 1'b0;
            m_last_p  = '0;
            m_last_id = 0;
            m_ptr     = N - 1;
        end else if (!m_job) begin
            if (w >= 0) begin
                ta      = req_a[16*w +: 16];
                tb      = req_b[16*w +: 16];
                m_job   = 1'b1;
                m_start = cyc;
                m_p     = 32'(int'(ta) * int'(tb));
                m_id    = w;
                m_ptr   = w;
            end
        end else if (exp_rv && rsp_ready) begin
            m_job     = 1'b0;
            m_last_p  = m_p;
            m_last_id = m_id;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Requesters withdraw valid once their operands were taken
    task automatic tick_drop();
        tick();
        req_valid = req_valid & ~seen_xfer;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n0;
        n0 = n_rsp;
        for (int k = 0; k < 20 && n_rsp == n0; k++) tick_drop();
        check({tag, "_done"}, 32'(n_rsp), 32'(n0 + 1));
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8 && m_job; k++) tick();
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    int corner_a[4]   = '{-32768, 32767, -1, -32768};
    int corner_b[4]   = '{-32768, 32767,  1,  32767};
    logic [31:0] corner_p[4] = '{32'h4000_0000, 32'h3FFF_0001, 32'hFFFF_FFFF, 32'hC000_8000};
`ifdef SMULT_ARB_ROUND_ROBIN_EN
    int exp_order[5] = '{0, 1, 2, 3, 0};
`else
    int exp_order[5] = '{0, 0, 0, 0, 0};
`endif

    initial begin
        int ones;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_p",     rsp_p,          32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // Single request from requester 2: 3 * -5
        set_req(2, 3, -5);
        tick_drop();
        check("t1_ready", 32'(last_ready), 32'h4);
        tick();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_p",     rsp_p,          32'hFFFF_FFF1);
        check("t1_rsp_id",    32'(rsp_id),    32'd2);
        check("t1_busy",      32'(busy),      32'd1);
        tick();
        check("t1_idle", 32'(busy), 32'd0);

        // Corner products through requester 0
        for (int i = 0; i < 4; i++) begin
            set_req(0, corner_a[i], corner_b[i]);
            wait_rsp("corner");
            check("corner_p",  rsp_seen_p,        corner_p[i]);
            check("corner_id", 32'(rsp_seen_id),  32'd0);
        end

        // All requesters valid continuously
        do_reset();
        grants.delete();
        for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
        for (int k = 0; k < 60 && grants.size() < 5; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (seen_xfer[i]) set_req(i, rand_op(), rand_op());
            end
        end
        check("order_count", 32'(grants.size()), 32'd5);
        for (int j = 0; j < 5; j++) begin
            check("order", 32'(j < grants.size() ? grants[j] : -1), 32'(exp_order[j]));
        end
        drain();

        // Back-pressure: hold rsp_ready low for 5 cycles in RESP
        do_reset();
        rsp_ready = 1'b0;
        set_req(1, 1234, -77);
        set_req(3, 5, 6);
        tick_drop();
        check("bp_accept", 32'(last_ready), 32'h2);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick_drop();
            check("bp_p",     rsp_p,           32'hFFFE_8CD6);
            check("bp_id",    32'(rsp_id),     32'd1);
            check("bp_ready", 32'(last_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick_drop();
        check("bp_idle", 32'(busy), 32'd0);
        tick_drop();
        check("bp_next_grant", 32'(last_ready), 32'h8);
        wait_rsp("bp_r3");
        check("bp_r3_p", rsp_seen_p, 32'd30);
        drain();

        // Reset during MUL and during RESP
        set_req(0, 100, 200);
        set_req(1, 7, 7);
        rsp_ready = 1'b1;
        tick();
        check("rm_accept", 32'(last_ready), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rm_rsp_p",     rsp_p,          32'd0);
        check("rm_busy",      32'(busy),      32'd0);
        tick();
        check("rm_regrant", 32'(last_ready), 32'h1);
        tick();
        check("rr_in_resp", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rr_rsp_p",     rsp_p,          32'd0);
        check("rr_rsp_id",    32'(rsp_id),    32'd0);
        check("rr_busy",      32'(busy),      32'd0);
        tick();
        check("rr_regrant", 32'(last_ready), 32'h1);
        drain();

        // Requester 1 withdraws before being granted
        begin
            int n0;
            n0 = n_rsp;
            grants.delete();
            set_req(0, -300, 11);
            tick_drop();
            set_req(1, 9, 9);
            tick_drop();
            req_valid[1] = 1'b0;
            for (int k = 0; k < 6; k++) tick_drop();
            ones = 0;
            foreach (grants[j]) if (grants[j] == 1) ones++;
            check("wd_rsp_count", 32'(n_rsp),       32'(n0 + 1));
            check("wd_rsp_id",    32'(rsp_seen_id), 32'd0);
            check("wd_rsp_p",     rsp_seen_p,       32'hFFFF_F31C);
            check("wd_no_r1",     32'(ones),        32'd0);
        end

        // Randomized traffic with back-pressure and occasional resets
        for (int c = 0; c < 500; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, rand_op(), rand_op());
            end
            tick_drop();
        end
        rst = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/smult_share_arbiter.md
# smult_share_arbiter

Shares the team's single combinational signed 16x16 array multiplier (`smult16bit`) among N_REQ requesters. The block has a valid/ready request port per requester and one valid/ready response port. It arbitrates, registers the operands in front of the multiplier, registers the 32-bit product behind it, and tags each result with the requester index. It sits between the DSP front-end clients and the multiplier and is the only driver of the multiplier inputs.

## Interface
- N_REQ, 4, number of requesters; supported range 2..8.
- ID_W, 2, width of the requester index; must equal clog2(N_REQ).
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_valid  input  N_REQ  bit i: requester i presents operands.
- req_ready  output  N_REQ  bit i: requester i's operands are accepted this cycle; one-hot or zero.
- req_a  input  16*N_REQ  slice [16i+15:16i]: signed multiplicand of requester i.
- req_b  input  16*N_REQ  slice [16i+15:16i]: signed multiplier of requester i.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts the product.
- rsp_p  output  32  signed product a*b, two's complement.
- rsp_id  output  ID_W  index of the requester that owns rsp_p.
- busy  output  1  high whenever state is not IDLE.

## Operation
- The FSM has three states: IDLE, MUL, RESP.
- **IDLE:**
  - grant = arbiter pick among req_valid; req_ready = grant (combinational, only in IDLE).
  - On a transfer (req_valid[i] & req_ready[i]), capture req_a/req_b slice i into op_a/op_b, capture i into op_id, update the priority pointer to i, and go to MUL.
  - With no valid request, stay in IDLE with req_ready = 0.
- **MUL:**
  - The multiplier is driven from op_a/op_b and has one full cycle to settle.
  - At the end of the cycle, register the product into rsp_p and op_id into rsp_id, then go to RESP.
  - req_ready = 0.
- **RESP:**
  - rsp_valid = 1; rsp_p and rsp_id are held stable.
  - When rsp_ready = 1, go to IDLE. No new request is accepted in that same cycle.
  - While rsp_ready = 0, hold indefinitely.
- **Arithmetic:** full-precision signed 16x16 -> 32 with no saturation; (-32768)*(-32768) = 0x40000000.
- **Request rules:**
  - A requester must hold valid, a and b stable until ready.
  - Deasserting valid before the grant is tolerated: the arbiter re-evaluates every cycle, so nothing is captured.
- **Operand registers:** op_a/op_b hold their last value in IDLE, so the multiplier inputs do not toggle while idle.
- **Reset** (any cycle, including mid-MUL/RESP):
  - State = IDLE; rsp_valid = 0, rsp_p = 0, rsp_id = 0, busy = 0, req_ready = 0 during reset.
  - op_a = op_b = 0; pointer = N_REQ-1. Any in-flight operation is discarded.

## Timing
- Accept in cycle T -> rsp_valid first high in cycle T+2.
- Best-case throughput is one product per 3 cycles (accept, MUL, RESP with rsp_ready already high).
- req_ready depends combinationally on req_valid and state. rsp_valid, rsp_p and rsp_id come directly from registers.
- Back-pressure: each cycle rsp_ready stays low adds one cycle; nothing is lost or reordered.
- Simultaneous requests: exactly one is granted per IDLE cycle. The losers keep valid and are served in later rounds.

## Configuration
- SMULT_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration; the search starts at pointer+1 modulo N_REQ.
  - After reset, requester 0 has the highest priority.
  - With continuous requests, a requester waits at most N_REQ-1 grants.
- Undefined:
  - Fixed priority; the lowest index wins. The pointer is not implemented.
  - Higher indices may starve.

## Test plan
- Reset, then a single request from requester 2 with a=3, b=-5, rsp_ready=1:
  - req_ready = 0b0100 in the accept cycle.
  - Two cycles later: rsp_valid=1, rsp_p=0xFFFFFFF1, rsp_id=2, busy=1.
  - Back to IDLE the next cycle.
- Corner products via requester 0 (rsp_ready=1):
  - -32768*-32768 -> 0x40000000.
  - 32767*32767 -> 0x3FFF0001.
  - -1*1 -> 0xFFFFFFFF.
  - -32768*32767 -> 0xC0008000.
- All four requesters valid continuously:
  - With the macro: grant order 0,1,2,3,0, products tagged correctly.
  - Without the macro: requester 0 is granted every round.
- Hold rsp_ready=0 for 5 cycles in RESP:
  - rsp_p and rsp_id stay stable, req_ready stays 0, no new capture.
  - After rsp_ready=1, IDLE follows and the next grant comes one cycle later.
- Assert rst for one cycle in MUL and again in RESP:
  - Next cycle: rsp_valid=0, rsp_p=0, busy=0.
  - The pending request is re-granted starting from requester 0 priority.
- Requester 1 raises valid, then drops it before a grant while requester 0 owns the multiplier:
  - No transaction for requester 1.
  - Exactly one response, with rsp_id=0.
